// File: rtl/adder_share_pkg.sv
// Shared types and constants for the adder-sharing controller.
package adder_share_pkg;

  localparam int DW_DEF    = 12;
  localparam int CNT_W_DEF = 8;
  localparam int ID_W_MAX  = 3;

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_e;

  typedef struct packed {
    logic [ID_W_MAX-1:0]  id;
    logic [DW_DEF-1:0]    sum;
    logic                 ovf;
    logic [CNT_W_DEF-1:0] beats;
  } rsp_t;

  function automatic int rr_next(int idx, int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Requester streams, shared-adder hookup and response channel of adder_share_ctrl.
interface adder_share_ctrl_if
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = DW_DEF,
  parameter int CNT_W   = CNT_W_DEF
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;
  logic [DW-1:0]         add_a;
  logic [DW-1:0]         add_b;
  logic [DW:0]           add_sum;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [DW-1:0]         rsp_sum;
  logic                  rsp_ovf;
  logic [CNT_W-1:0]      rsp_beats;

  modport slave (
    input  req_valid, req_data, req_last, add_sum, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_ovf, rsp_beats
  );

  modport master (
    output req_valid, req_data, req_last, add_sum, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_ovf, rsp_beats
  );

endinterface

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, circularly.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDW-1:0]     gnt_idx_o,
  output logic               any_o
);

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_o && req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
        any_o     = 1'b1;
        gnt_idx_o = IDW'((int'(ptr_i) + k) % NUM_REQ);
        gnt_oh_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin burst accumulator time-sharing one external DW-bit adder.
// Define ADDER_SHARE_SAT_EN to saturate the sum at all-ones on carry-out.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = DW_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic          clk,
  input logic          rst_n,
  adder_share_ctrl_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d, gnt_q, gnt_d;
  logic [NUM_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic [DW-1:0]      acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   beats_q, beats_d;
  rsp_t               rsp_q, rsp_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IDW-1:0]     arb_idx;
  logic               arb_any;
  logic               beat, carry, ovf_nx;
  logic [DW-1:0]      acc_nx;
  logic [CNT_W-1:0]   beats_nx;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req_i    (bus.req_valid),
    .ptr_i    (rr_ptr_q),
    .gnt_oh_o (arb_oh),
    .gnt_idx_o(arb_idx),
    .any_o    (arb_any)
  );

  assign beat  = (state_q == ACC) && bus.req_valid[gnt_q];
  assign carry = bus.add_sum[DW];
`ifdef ADDER_SHARE_SAT_EN
  // once a carry has been seen the sum is pinned at all-ones
  assign acc_nx = (carry || ovf_q) ? '1 : bus.add_sum[DW-1:0];
`else
  assign acc_nx = bus.add_sum[DW-1:0];
`endif
  assign ovf_nx   = ovf_q | carry;
  assign beats_nx = (&beats_q) ? beats_q : beats_q + 1'b1;

  assign bus.req_ready = (state_q == ACC) ? gnt_oh_q : '0;
  assign bus.add_a     = (state_q == ACC) ? acc_q : '0;
  assign bus.add_b     = (state_q == ACC) ? bus.req_data[int'(gnt_q)*DW +: DW] : '0;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = IDW'(rsp_q.id);
  assign bus.rsp_sum   = rsp_q.sum;
  assign bus.rsp_ovf   = rsp_q.ovf;
  assign bus.rsp_beats = rsp_q.beats;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      gnt_oh_q <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      beats_q  <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      gnt_oh_q <= gnt_oh_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      beats_q  <= beats_d;
      rsp_q    <= rsp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    gnt_oh_d = gnt_oh_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    beats_d  = beats_q;
    rsp_d    = rsp_q;
    case (state_q)
      IDLE: if (arb_any) begin
        gnt_d    = arb_idx;
        gnt_oh_d = arb_oh;
        acc_d    = '0;
        ovf_d    = 1'b0;
        beats_d  = '0;
        state_d  = ACC;
      end
      ACC: if (beat) begin
        acc_d   = acc_nx;
        ovf_d   = ovf_nx;
        beats_d = beats_nx;
        if (bus.req_last[gnt_q]) begin
          rsp_d.id    = ID_W_MAX'(gnt_q);
          rsp_d.sum   = acc_nx;
          rsp_d.ovf   = ovf_nx;
          rsp_d.beats = beats_nx;
          state_d     = RESP;
        end
      end
      RESP: if (bus.rsp_ready) begin
        rr_ptr_d = IDW'(rr_next(int'(gnt_q), NUM_REQ));
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed + randomized bench for adder_share_ctrl against an integer-sum burst model.
module tb_adder_share_ctrl;
  localparam int N  = 4;
  localparam int DW = 12;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_share_ctrl_if #(.NUM_REQ(N), .DW(DW), .CNT_W(CW)) bus ();
  assign bus.add_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};

  adder_share_ctrl #(.NUM_REQ(N), .DW(DW), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int ptr_m = 0;
  int ops[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh_of(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_op(input int id, input int v, input logic last);
    bus.req_data[id*DW +: DW] = DW'(v);
    bus.req_last[id]          = last;
  endtask

  // Drives ops[] as one burst from requester id and checks the response.
  task automatic send_burst(input int id, input int bub_at, input int hold);
    int total, n, w;
    logic [DW-1:0] e_sum;
    logic          e_ovf;
    logic [CW-1:0] e_beats;
    logic [N-1:0]  oh;
    oh = oh_of(id);
    n = ops.size();
    total = 0;
    foreach (ops[i]) total += ops[i];
    e_ovf = (total > 4095);
`ifdef ADDER_SHARE_SAT_EN
    e_sum = e_ovf ? 12'hFFF : DW'(total % 4096);
`else
    e_sum = DW'(total % 4096);
`endif
    e_beats = (n > 255) ? CW'(255) : CW'(n);
    for (int b = 0; b < n; b++) begin
      if (b == bub_at && b > 0) begin
        bus.req_valid = ~oh;
        repeat (3) begin
          @(negedge clk);
          chk("bubble_lock", 32'(bus.req_ready), 32'(oh));
        end
        bus.req_valid = '0;
      end
      bus.req_valid[id] = 1'b1;
      set_op(id, ops[b], (b == n - 1));
      w = 0;
      while (bus.req_ready !== oh && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (b == 0) chk("grant_latency", 32'(w), 32'd1);
      else        chk("beat_wait", 32'(w), 32'd0);
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
    chk("rsp_latency", 32'(bus.rsp_valid), 32'd1);
    bus.req_valid = (hold > 0) ? ~oh : '0;
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(id));
      chk("rsp_sum", 32'(bus.rsp_sum), 32'(e_sum));
      chk("rsp_ovf", 32'(bus.rsp_ovf), 32'(e_ovf));
      chk("rsp_beats", 32'(bus.rsp_beats), 32'(e_beats));
      if (hold > 0) chk("rsp_no_grant", 32'(bus.req_ready), 32'd0);
      if (h < hold) @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b0;
    ptr_m = (id + 1) % N;
  endtask

  initial begin
    int exp_id, got, cyc, n, id, bub, w;
    logic [DW-1:0] last_d;

    // reset with every input active
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.req_last  = '1;
    bus.req_data  = {$urandom, $urandom};
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    chk("rst_rsp_ovf", 32'(bus.rsp_ovf), 32'd0);
    chk("rst_rsp_beats", 32'(bus.rsp_beats), 32'd0);
    chk("rst_add_a", 32'(bus.add_a), 32'd0);
    chk("rst_add_b", 32'(bus.add_b), 32'd0);
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(bus.req_ready), 32'd0);
    chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    ops = {'h100, 'h200, 'h0FF};
    send_burst(1, -1, 0);
    ops = {'hFFF, 'h002};
    send_burst(0, -1, 0);
    ops = {int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095))};
    send_burst(2, 2, 0);
    ops = {int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095))};
    send_burst(3, -1, 5);

    // round robin with every requester continuously valid
    for (int i = 0; i < N; i++) set_op(i, int'($urandom_range(0, 4095)), 1'b1);
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    exp_id = ptr_m;
    got = 0;
    cyc = 0;
    last_d = '0;
    while (got < 5 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
      if (bus.req_ready != '0) begin
        chk("rr_grant", 32'(bus.req_ready), 32'(oh_of(exp_id)));
        last_d = bus.req_data[exp_id*DW +: DW];
      end
      if (bus.rsp_valid) begin
        chk("rr_id", 32'(bus.rsp_id), 32'(exp_id));
        chk("rr_sum", 32'(bus.rsp_sum), 32'(last_d));
        chk("rr_ovf", 32'(bus.rsp_ovf), 32'd0);
        chk("rr_beats", 32'(bus.rsp_beats), 32'd1);
        set_op(exp_id, int'($urandom_range(0, 4095)), 1'b1);
        exp_id = (exp_id + 1) % N;
        got++;
      end
    end
    chk("rr_count", 32'(got), 32'd5);
    bus.req_valid = '0;
    bus.req_last  = '0;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    ptr_m = exp_id;
    @(negedge clk);

    // randomized bursts
    for (int r = 0; r < 8; r++) begin
      id = int'($urandom_range(0, N - 1));
      n  = int'($urandom_range(1, 5));
      ops = {};
      for (int b = 0; b < n; b++) ops.push_back(int'($urandom_range(0, 4095)));
      bub = (n > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 1)) : -1;
      send_burst(id, bub, int'($urandom_range(0, 3)));
    end

    // beat counter saturation
    ops = {};
    for (int b = 0; b < 260; b++) ops.push_back(int'($urandom_range(0, 3)));
    send_burst(3, -1, 0);

    // reset after 2 of 4 beats: no response, then a fresh sum
    bus.req_valid[0] = 1'b1;
    set_op(0, 'h111, 1'b0);
    w = 0;
    while (bus.req_ready[0] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("mr_grant", 32'(w), 32'd1);
    @(negedge clk);
    set_op(0, 'h222, 1'b0);
    @(negedge clk);
    set_op(0, 'h333, 1'b0);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mr_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mr_rst_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    ptr_m = 0;
    ops = {'h005};
    send_burst(0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
